// File: rtl/rl_pair_filter.sv
// Range-limited pair filter: compares each pair's r2 against cutoff2 and queues the
// survivors in a first-word-fall-through buffer feeding the force evaluator.
module rl_pair_filter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 9,
    parameter int FIFO_DEPTH      = 8,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r2_valid,
    input  logic [DATA_WIDTH-1:0] r2,
    input  logic [ID_WIDTH-1:0]   home_id,
    input  logic [ID_WIDTH-1:0]   nb_id,
    input  logic [DATA_WIDTH-1:0] cutoff2,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_r2,
    output logic [ID_WIDTH-1:0]   out_home_id,
    output logic [ID_WIDTH-1:0]   out_nb_id,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [15:0]           pass_count,
    output logic [15:0]           drop_count
);

    localparam int CNT_W = FIFO_ADDR_WIDTH + 1;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] r2_p1;
    logic [ID_WIDTH-1:0]   home_p1;
    logic [ID_WIDTH-1:0]   nb_p1;

    logic [DATA_WIDTH-1:0] mem_r2   [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   mem_home [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   mem_nb   [FIFO_DEPTH];

    logic [FIFO_ADDR_WIDTH-1:0] wptr;
    logic [FIFO_ADDR_WIDTH-1:0] rptr;
    logic [CNT_W-1:0]           count;

    logic pass_p1, drop_p1, full, pop, push, lost;
    logic unused_cutoff_sign;

    // For positive, finite floats the raw magnitude bits order the same way as the values.
    function automatic logic is_pass(input logic [DATA_WIDTH-1:0] v,
                                     input logic [DATA_WIDTH-1:0] c);
        return !v[31] && (v[30:0] != 31'd0) && (v[30:23] != 8'hFF) && (v[30:0] < c[30:0]);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign unused_cutoff_sign = cutoff2[DATA_WIDTH-1];

    assign pass_p1 = vld_p1 && is_pass(r2_p1, cutoff2);
    assign drop_p1 = vld_p1 && !pass_p1;
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = (count != '0) && out_ready;
    assign push    = pass_p1 && (!full || pop);
    assign lost    = pass_p1 && full && !pop;

    assign out_valid   = (count != '0);
    assign out_r2      = out_valid ? mem_r2[rptr]   : '0;
    assign out_home_id = out_valid ? mem_home[rptr] : '0;
    assign out_nb_id   = out_valid ? mem_nb[rptr]   : '0;
    assign almost_full = (count >= CNT_W'(FIFO_DEPTH - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            pass_count <= '0;
            drop_count <= '0;
        end else begin
            vld_p1 <= r2_valid;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (lost) overflow <= 1'b1;
            if (push) pass_count <= sat_inc(pass_count);
            if (drop_p1 || lost) drop_count <= sat_inc(drop_count);
        end
    end

    // S1 capture and buffer write; data paths carry no reset, validity is tracked above.
    always_ff @(posedge clk) begin
        r2_p1   <= r2;
        home_p1 <= home_id;
        nb_p1   <= nb_id;
        if (push) begin
            mem_r2[wptr]   <= r2_p1;
            mem_home[wptr] <= home_p1;
            mem_nb[wptr]   <= nb_p1;
        end
    end

endmodule

// File: doc/rl_pair_filter.md
RL_PAIR_FILTER -- requirements
Module: rl_pair_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of r2 and cutoff (IEEE-754 single).
REQ-002 SHALL have parameter ID_WIDTH, default 9, width of home/neighbor particle index.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, output buffer entries (power of two, >=4).
REQ-004 SHALL have parameter FIFO_ADDR_WIDTH, default 3, equal to log2(FIFO_DEPTH).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port r2_valid  input  1  r2 and ids valid this cycle.
REQ-008 SHALL have port r2  input  DATA_WIDTH  squared distance from r2 stage.
REQ-009 SHALL have port home_id  input  ID_WIDTH  home particle index of the pair.
REQ-010 SHALL have port nb_id  input  ID_WIDTH  neighbor particle index of the pair.
REQ-011 SHALL have port cutoff2  input  DATA_WIDTH  squared cutoff radius, positive float, static during operation.
REQ-012 SHALL have port out_ready  input  1  downstream force evaluator accepts entry.
REQ-013 SHALL have port out_valid  output  1  buffer head valid.
REQ-014 SHALL have port out_r2  output  DATA_WIDTH  r2 of head entry.
REQ-015 SHALL have port out_home_id  output  ID_WIDTH  home index of head entry.
REQ-016 SHALL have port out_nb_id  output  ID_WIDTH  neighbor index of head entry.
REQ-017 SHALL have port almost_full  output  1  backpressure to pair address generator.
REQ-018 SHALL have port overflow  output  1  sticky: passing pair lost due to full buffer.
REQ-019 SHALL have ports pass_count, drop_count  output  16 each  saturating statistics.

Function
REQ-020 SHALL register r2, ids and r2_valid into a compare stage on the edge r2_valid is sampled (stage S1).
REQ-021 SHALL classify S1 pair as pass iff: sign bit 0, bits [30:0] nonzero, exponent not all ones, and r2[30:0] < cutoff2[30:0] as unsigned integers (strict).
REQ-022 SHALL treat all other S1 pairs (negative, zero/self-pair, Inf/NaN, r2 >= cutoff2) as dropped; no buffer write.
REQ-023 SHALL write a passing S1 pair into the buffer at the end of S1, so out_valid rises 2 cycles after r2_valid sample when the buffer was empty.
REQ-024 SHALL present buffer as first-word-fall-through: out_valid = count != 0; out_* = head entry, held stable while out_valid && !out_ready.
REQ-025 SHALL pop the head on a cycle with out_valid && out_ready.
REQ-026 SHALL accept a push when full if a pop occurs in the same cycle; count unchanged.
REQ-027 SHALL, on push while full without pop, discard the new pair, keep contents, set overflow, increment drop_count.
REQ-028 SHALL, on simultaneous push and pop with count 0 < n < FIFO_DEPTH, keep count n and preserve order.
REQ-029 SHALL wrap read/write pointers modulo FIFO_DEPTH; count is FIFO_ADDR_WIDTH+1 bits.
REQ-030 SHALL assert almost_full combinationally when count >= FIFO_DEPTH-2 (covers 2-cycle upstream reaction).
REQ-031 SHALL increment pass_count per buffered pair and drop_count per rejected or overflowed pair; both saturate at 16'hFFFF.
REQ-032 SHALL ignore out_ready when out_valid is 0.

Reset
REQ-033 SHALL on rst clear S1 valid, pointers, count, overflow, pass_count, drop_count; out_valid=0, almost_full=0.
REQ-034 SHALL on rst reset out_r2, out_home_id, out_nb_id to 0.
REQ-035 SHALL on rst mid-operation discard all buffered and in-flight pairs; r2_valid in the rst cycle ignored.

Verification
REQ-036 SHALL cover: cutoff2=0x41000000(8.0), r2=0x40800000(4.0), ids 3/7, out_ready=1 -> out_valid 2 cycles later, out_r2=0x40800000, home 3, nb 7, pass_count=1.
REQ-037 SHALL cover: r2=0x41000000 (equal), then 0x00000000, then 0x7FC00000 (NaN) -> no out_valid, drop_count=3.
REQ-038 SHALL cover: out_ready=0, 10 passing pairs back-to-back, FIFO_DEPTH=8 -> almost_full at count 6, 8 entries held in order, overflow=1, drop_count=2.
REQ-039 SHALL cover: buffer full, out_ready=1 and passing pair same cycle -> pair accepted, overflow stays 0, count stays 8.
REQ-040 SHALL cover: rst asserted with 5 entries buffered and pair in S1 -> next cycle out_valid=0, counts 0, later traffic in order from empty.
